// File: rtl/uc_multiciclo.sv
// Multi-cycle control FSM for the RV32I datapath.
// One shared memory port, ready handshake, wait-timeout fault.
module uc_multiciclo #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] selector,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       branch,
    output logic       jump,
    output logic [1:0] imm_sel,
    output logic       lui_op,
    output logic       wd_src,
    output logic       alu_src,
    output logic       alu_op,
    output logic       mem2reg,
    output logic       reg_write_en,
    output logic [2:0] state,
    output logic       illegal,
    output logic       instr_retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam bit TMO_EN = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic is_load, is_imm, is_store, is_branch, is_lui, is_jal, known;
    logic pending, timeout;

    logic       req_c, we_c, irw_c, pcw_c, br_c, jmp_c;
    logic       lui_c, wd_c, asrc_c, aop_c, m2r_c, rw_c, ret_c;
    logic [1:0] imm_c;

    assign is_load   = (selector == OP_LOAD);
    assign is_imm    = (selector == OP_IMM);
    assign is_store  = (selector == OP_STORE);
    assign is_branch = (selector == OP_BRANCH);
    assign is_lui    = (selector == OP_LUI);
    assign is_jal    = (selector == OP_JAL);
    assign known     = is_load | is_imm | is_store
                     | is_branch | is_lui | is_jal;

    always_comb begin
        req_c  = 1'b0;
        we_c   = 1'b0;
        irw_c  = 1'b0;
        pcw_c  = 1'b0;
        br_c   = 1'b0;
        jmp_c  = 1'b0;
        imm_c  = 2'b00;
        lui_c  = 1'b0;
        wd_c   = 1'b0;
        asrc_c = 1'b0;
        aop_c  = 1'b0;
        m2r_c  = 1'b0;
        rw_c   = 1'b0;
        ret_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                irw_c = mem_ready;
            end
            S_EXEC: begin
                if (is_load || is_imm) asrc_c = 1'b1;
                if (is_store) begin
                    asrc_c = 1'b1;
                    imm_c  = 2'b01;
                end
                if (is_branch) begin
                    br_c  = 1'b1;
                    imm_c = 2'b10;
                    aop_c = 1'b1;
                    pcw_c = 1'b1;
                    ret_c = 1'b1;
                end
                if (is_jal) imm_c = 2'b11;
            end
            S_MEM: begin
                req_c  = 1'b1;
                we_c   = is_store;
                asrc_c = 1'b1;
                imm_c  = is_store ? 2'b01 : 2'b00;
                if (is_store && mem_ready) begin
                    pcw_c = 1'b1;
                    ret_c = 1'b1;
                end
            end
            S_WB: begin
                rw_c  = 1'b1;
                pcw_c = 1'b1;
                ret_c = 1'b1;
                if (is_imm) begin
                    m2r_c  = 1'b1;
                    asrc_c = 1'b1;
                end
                if (is_lui) begin
                    lui_c = 1'b1;
                    wd_c  = 1'b1;
                end
                if (is_jal) begin
                    jmp_c = 1'b1;
                    wd_c  = 1'b1;
                    imm_c = 2'b11;
                end
            end
            default: ;
        endcase
    end

    // A request still unanswered after WAIT_MAX pending cycles is fatal.
    assign pending = req_c & ~mem_ready;
    assign timeout = TMO_EN && pending && (cnt_q == LIMIT);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        cnt_d     = pending ? cnt_q + 1'b1 : '0;
        case (state_q)
            S_FETCH: begin
                if (timeout)        state_d = S_FAULT;
                else if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_lui)     state_d = S_WB;
                else if (known) state_d = S_EXEC;
                else            state_d = S_FAULT;
            end
            S_EXEC: begin
                if (is_branch)                state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else if (is_imm || is_jal)    state_d = S_WB;
                else                          state_d = S_FAULT;
            end
            S_MEM: begin
                if (timeout)        state_d = S_FAULT;
                else if (mem_ready) state_d = is_store ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FAULT;
        endcase
        if (state_d == S_FAULT) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_req       = ~rst & req_c;
    assign mem_we        = ~rst & we_c;
    assign ir_write      = ~rst & irw_c;
    assign pc_write      = ~rst & pcw_c;
    assign pc_src        = ~rst & ((br_c & zero) | jmp_c);
    assign branch        = ~rst & br_c;
    assign jump          = ~rst & jmp_c;
    assign imm_sel       = rst ? 2'b00 : imm_c;
    assign lui_op        = ~rst & lui_c;
    assign wd_src        = ~rst & wd_c;
    assign alu_src       = ~rst & asrc_c;
    assign alu_op        = ~rst & aop_c;
    assign mem2reg       = ~rst & m2r_c;
    assign reg_write_en  = ~rst & rw_c;
    assign state         = rst ? 3'd0 : state_q;
    assign illegal       = ~rst & illegal_q;
    assign instr_retired = ~rst & ret_c;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: per-instruction step plans as reference,
// directed table, corner sequences and randomized instruction stream.
module tb_uc_multiciclo;

    localparam int WMAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] selector;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_write, pc_write, pc_src;
    logic       branch, jump, lui_op, wd_src, alu_src, alu_op;
    logic       mem2reg, reg_write_en, illegal, instr_retired;
    logic [1:0] imm_sel;
    logic [2:0] state;

    always #5 clk = ~clk;

    uc_multiciclo #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .selector(selector), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .branch(branch), .jump(jump), .imm_sel(imm_sel),
        .lui_op(lui_op), .wd_src(wd_src), .alu_src(alu_src),
        .alu_op(alu_op), .mem2reg(mem2reg),
        .reg_write_en(reg_write_en), .state(state),
        .illegal(illegal), .instr_retired(instr_retired)
    );

    localparam logic [4:0] LD = 5'b00000, OI = 5'b00100;
    localparam logic [4:0] ST = 5'b01000, BR = 5'b11000;
    localparam logic [4:0] LU = 5'b01101, JL = 5'b11011;

    int checks = 0;
    int errors = 0;

    // Reference: the remaining steps of the current instruction.
    // Step numbers are the visible state codes.
    int plan[$];
    int pend;
    int retired_cnt = 0;
    int regwr_cnt = 0;

    function automatic void build_plan(input logic [4:0] s);
        case (s)
            LD:      plan = '{0, 1, 2, 3, 4};
            OI:      plan = '{0, 1, 2, 4};
            ST:      plan = '{0, 1, 2, 3};
            BR:      plan = '{0, 1, 2};
            LU:      plan = '{0, 1, 4};
            JL:      plan = '{0, 1, 2, 4};
            default: plan = '{0, 1, 7};
        endcase
        pend = 0;
    endfunction

    function automatic void ensure_plan();
        if (plan.size() == 0) build_plan(selector);
    endfunction

    function automatic void advance(input logic rdy);
        int s;
        s = plan[0];
        if (s == 7) return;
        if ((s == 0 || s == 3) && !rdy) begin
            pend++;
            if (pend == WMAX) plan = '{7};
            return;
        end
        pend = 0;
        void'(plan.pop_front());
    endfunction

    // {req,we,irw,pcw,pcsrc,br,jmp,lui,wd,asrc,aop,m2r,rw,imm,state,ill,ret}
    function automatic logic [19:0] exp_out(input int s, input logic [4:0] sl,
                                            input logic z, input logic rdy);
        logic req, we, irw, pcw, br, jmp, lui, wd, as, ao, m2r, rw, ill, ret;
        logic [1:0] imm;
        {req, we, irw, pcw, br, jmp, lui, wd, as, ao, m2r, rw, ill, ret} = '0;
        imm = 2'b00;
        case (s)
            0: begin req = 1; irw = rdy; end
            2: begin
                if (sl == LD || sl == OI) as = 1;
                if (sl == ST) begin as = 1; imm = 2'b01; end
                if (sl == BR) begin
                    br = 1; imm = 2'b10; ao = 1; pcw = 1; ret = 1;
                end
                if (sl == JL) imm = 2'b11;
            end
            3: begin
                req = 1; as = 1;
                we = (sl == ST);
                imm = (sl == ST) ? 2'b01 : 2'b00;
                if (sl == ST && rdy) begin pcw = 1; ret = 1; end
            end
            4: begin
                rw = 1; pcw = 1; ret = 1;
                if (sl == OI) begin m2r = 1; as = 1; end
                if (sl == LU) begin lui = 1; wd = 1; end
                if (sl == JL) begin jmp = 1; wd = 1; imm = 2'b11; end
            end
            7: ill = 1;
            default: ;
        endcase
        return {req, we, irw, pcw, (br & z) | jmp, br, jmp, lui, wd,
                as, ao, m2r, rw, imm, 3'(s), ill, ret};
    endfunction

    function automatic logic [19:0] act_out();
        return {mem_req, mem_we, ir_write, pc_write, pc_src, branch, jump,
                lui_op, wd_src, alu_src, alu_op, mem2reg, reg_write_en,
                imm_sel, state, illegal, instr_retired};
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, exp);
        end
    endtask

    // Called at a negedge with inputs already applied; returns at next negedge.
    task automatic step_cycle(input string tag);
        logic [19:0] e, a;
        ensure_plan();
        #1;
        e = rst ? 20'h0 : exp_out(plan[0], selector, zero, mem_ready);
        a = act_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t outputs got %05h want %05h",
                     tag, $time, a, e);
        end
        retired_cnt += int'(instr_retired);
        regwr_cnt   += int'(reg_write_en);
        if (rst) begin
            plan.delete();
            pend = 0;
        end else begin
            advance(mem_ready);
        end
        @(negedge clk);
    endtask

    // Runs one instruction; memory answers after fw/mw pending cycles.
    task automatic run_instr(input logic [4:0] sl, input logic z,
                             input int fw, input int mw, input string tag,
                             output int cyc, output int ret, output int rw);
        int r0, w0, s;
        r0 = retired_cnt;
        w0 = regwr_cnt;
        selector = sl;
        zero = z;
        rst = 1'b0;
        cyc = 0;
        forever begin
            ensure_plan();
            s = plan[0];
            if (s == 0)      mem_ready = (pend >= fw);
            else if (s == 3) mem_ready = (pend >= mw);
            else             mem_ready = 1'($urandom_range(0, 1));
            step_cycle(tag);
            cyc++;
            if (plan.size() == 0 || plan[0] == 7) break;
            if (cyc > 60) begin
                chk({tag, "_bound"}, cyc, -1);
                break;
            end
        end
        ret = retired_cnt - r0;
        rw  = regwr_cnt - w0;
    endtask

    typedef struct {
        string      name;
        logic [4:0] sel;
        logic       z;
        int         fw;
        int         mw;
        int         cyc;
        int         ret;
        int         rw;
    } vec_t;

    vec_t vt[$];

    initial begin
        int cyc, ret, rw, r0, w0;
        vt = '{
            '{"opimm",   OI, 1'b0, 0, 0, 4, 1, 1},
            '{"load_w",  LD, 1'b0, 3, 2, 10, 1, 1},
            '{"br_z1",   BR, 1'b1, 0, 0, 3, 1, 0},
            '{"br_z0",   BR, 1'b0, 0, 0, 3, 1, 0},
            '{"store",   ST, 1'b0, 0, 0, 4, 1, 0},
            '{"jal",     JL, 1'b1, 0, 0, 4, 1, 1},
            '{"lui",     LU, 1'b0, 0, 0, 3, 1, 1},
            '{"load",    LD, 1'b1, 0, 0, 5, 1, 1},
            '{"store_w", ST, 1'b0, 1, 3, 8, 1, 0},
            '{"jal_w",   JL, 1'b0, 2, 0, 6, 1, 1}
        };

        rst = 1'b1;
        selector = OI;
        zero = 1'b0;
        mem_ready = 1'b1;
        plan.delete();
        pend = 0;
        @(negedge clk);
        step_cycle("reset0");
        mem_ready = 1'b0;
        step_cycle("reset1");
        rst = 1'b0;

        foreach (vt[i]) begin
            run_instr(vt[i].sel, vt[i].z, vt[i].fw, vt[i].mw, vt[i].name,
                      cyc, ret, rw);
            chk({vt[i].name, "_cycles"}, cyc, vt[i].cyc);
            chk({vt[i].name, "_retired"}, ret, vt[i].ret);
            chk({vt[i].name, "_regwr"}, rw, vt[i].rw);
        end

        // Reset in the middle of a load's MEM phase
        r0 = retired_cnt;
        w0 = regwr_cnt;
        selector = LD;
        mem_ready = 1'b1;
        step_cycle("rmem_f");
        step_cycle("rmem_d");
        step_cycle("rmem_x");
        mem_ready = 1'b0;
        step_cycle("rmem_m");
        rst = 1'b1;
        step_cycle("rmem_rst");
        rst = 1'b0;
        #1;
        chk("rmem_state", int'(state), 0);
        chk("rmem_regwr", regwr_cnt - w0, 0);
        chk("rmem_retired", retired_cnt - r0, 0);
        #1;
        run_instr(OI, 1'b0, 0, 0, "after_rmem", cyc, ret, rw);
        chk("after_rmem_cycles", cyc, 4);

        // Unknown selector: sticky fault until reset
        run_instr(5'b11111, 1'b0, 0, 0, "badsel", cyc, ret, rw);
        chk("badsel_cycles", cyc, 2);
        r0 = retired_cnt;
        w0 = regwr_cnt;
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            step_cycle("fault_hold");
        end
        chk("fault_regwr", regwr_cnt - w0, 0);
        chk("fault_retired", retired_cnt - r0, 0);
        #1;
        chk("fault_illegal", int'(illegal), 1);
        chk("fault_state", int'(state), 7);
        #1;
        rst = 1'b1;
        step_cycle("fault_rst");
        rst = 1'b0;
        #1;
        chk("fault_clr_state", int'(state), 0);
        chk("fault_clr_illegal", int'(illegal), 0);
        #1;

        // Memory never answers during fetch
        run_instr(OI, 1'b0, 100, 0, "tmo_fetch", cyc, ret, rw);
        chk("tmo_fetch_cycles", cyc, WMAX);
        mem_ready = 1'b1;
        step_cycle("tmo_fault");
        rst = 1'b1;
        step_cycle("tmo_rst");
        rst = 1'b0;

        // Memory answers just before timeout in MEM
        run_instr(LD, 1'b0, 0, WMAX - 1, "mem_edge", cyc, ret, rw);
        chk("mem_edge_cycles", cyc, 5 + WMAX - 1);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [4:0] sl;
            int pick, fw, mw;
            pick = $urandom_range(0, 19);
            case (pick % 7)
                0: sl = LD;
                1: sl = OI;
                2: sl = ST;
                3: sl = BR;
                4: sl = LU;
                5: sl = JL;
                default: sl = (pick > 17) ? 5'($urandom) : OI;
            endcase
            fw = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
            run_instr(sl, 1'($urandom_range(0, 1)), fw, mw, "rnd",
                      cyc, ret, rw);
            if (plan.size() != 0 && plan[0] == 7) begin
                mem_ready = 1'($urandom_range(0, 1));
                step_cycle("rnd_fault");
                rst = 1'b1;
                step_cycle("rnd_rst");
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
